// File: rtl/id_ex_issue_buf_pkg.sv
// Shared decode/execute encodings: datapath widths, one-hot opinfo and ALU bit indices,
// and the packed issue payload carried from IDU to EXU.
package id_ex_issue_buf_pkg;

   localparam int XLEN     = 64;
   localparam int OPINFO_W = 12;
   localparam int ALU_W    = 10;
   localparam int RIDX_W   = 5;

   // opinfo one-hot bit positions
   localparam int OP_ALU   = 0;
   localparam int OP_ALUI  = 1;
   localparam int OP_ALUW  = 2;
   localparam int OP_ALUIW = 3;
   localparam int OP_BRANCH = 4;
   localparam int OP_JAL   = 5;
   localparam int OP_JALR  = 6;
   localparam int OP_LOAD  = 7;
   localparam int OP_STORE = 8;
   localparam int OP_LUI   = 9;
   localparam int OP_AUIPC = 10;
   localparam int OP_SYS   = 11;

   // ALU op one-hot bit positions
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_XOR  = 2;
   localparam int ALU_OR   = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_SLL  = 5;
   localparam int ALU_SRL  = 6;
   localparam int ALU_SRA  = 7;
   localparam int ALU_SLT  = 8;
   localparam int ALU_SLTU = 9;

   typedef struct packed {
      logic [OPINFO_W-1:0] opinfo;
      logic [ALU_W-1:0]    alu;
      logic [XLEN-1:0]     pc;
      logic [XLEN-1:0]     src1;
      logic [XLEN-1:0]     src2;
      logic [XLEN-1:0]     imm;
      logic [RIDX_W-1:0]   rd;
      logic                rd_wen;
   } issue_t;

   localparam int ISSUE_W = $bits(issue_t);

endpackage

// File: rtl/issue_skid_reg.sv
// Purpose: generic two-entry (main + skid) registered pipeline stage, flushable.
// Latency: one cycle from accept to out_valid when main is empty.
// Backpressure: in_ready = ~skid_v, registered; no combinational path from out_ready.
module issue_skid_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_v;
   logic         skid_v;
   logic [W-1:0] main_d;
   logic [W-1:0] skid_d;
   logic         drain;
   logic         accept;

   assign drain  = main_v & out_ready;
   assign accept = in_valid & ~skid_v;

   // With skid occupied, upstream is stalled, so only the skid->main move can happen.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_d <= '0;
         skid_d <= '0;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else if (skid_v) begin
         if (drain) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
         end
      end else if (accept) begin
         if (!main_v || drain) begin
            main_d <= in_data;
            main_v <= 1'b1;
         end else begin
            skid_d <= in_data;
            skid_v <= 1'b1;
         end
      end else if (drain) begin
         main_v <= 1'b0;
      end
   end

   assign in_ready  = ~skid_v;
   assign out_valid = main_v;
   assign out_data  = main_d;

   a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) skid_v |-> main_v);

endmodule

// File: rtl/id_ex_issue_buf.sv
// Purpose: ID->EX issue buffer; masks opinfo/alu/rd_wen on bubbles. IDEX_ISSUE_BYPASS_EN adds empty-buffer bypass.
// Latency: one cycle (zero when bypassing an empty buffer).
// Backpressure: two-entry skid; in_ready_o is registered (~skid_v).
module id_ex_issue_buf
   import id_ex_issue_buf_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [OPINFO_W-1:0] in_opinfo_i,
   input  logic [ALU_W-1:0]    in_alu_i,
   input  logic [XLEN-1:0]     in_pc_i,
   input  logic [XLEN-1:0]     in_src1_i,
   input  logic [XLEN-1:0]     in_src2_i,
   input  logic [XLEN-1:0]     in_imm_i,
   input  logic [RIDX_W-1:0]   in_rd_i,
   input  logic                in_rd_wen_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [OPINFO_W-1:0] out_opinfo_o,
   output logic [ALU_W-1:0]    out_alu_o,
   output logic [XLEN-1:0]     out_pc_o,
   output logic [XLEN-1:0]     out_src1_o,
   output logic [XLEN-1:0]     out_src2_o,
   output logic [XLEN-1:0]     out_imm_o,
   output logic [RIDX_W-1:0]   out_rd_o,
   output logic                out_rd_wen_o
);

   issue_t in_p;
   issue_t main_p;
   issue_t sel_p;
   logic   main_v;
   logic   store_vld;
   logic   out_vld;

   assign in_p = '{opinfo: in_opinfo_i, alu: in_alu_i, pc: in_pc_i, src1: in_src1_i,
                   src2: in_src2_i, imm: in_imm_i, rd: in_rd_i, rd_wen: in_rd_wen_i};

`ifdef IDEX_ISSUE_BYPASS_EN
   logic byp;
   // Empty main implies empty skid, so main_v alone qualifies the bypass.
   assign byp       = ~main_v & in_valid_i & ~flush_i;
   assign store_vld = in_valid_i & ~(byp & out_ready_i);
   assign out_vld   = main_v | byp;
   assign sel_p     = byp ? in_p : main_p;
`else
   assign store_vld = in_valid_i;
   assign out_vld   = main_v;
   assign sel_p     = main_p;
`endif

   issue_skid_reg #(.W(ISSUE_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .in_valid  (store_vld),
      .in_ready  (in_ready_o),
      .in_data   (in_p),
      .out_valid (main_v),
      .out_ready (out_ready_i),
      .out_data  (main_p)
   );

   // Bubbles must look like a no-op to the ALU: zero result, no writeback.
   assign out_valid_o  = out_vld;
   assign out_opinfo_o = out_vld ? sel_p.opinfo : '0;
   assign out_alu_o    = out_vld ? sel_p.alu    : '0;
   assign out_rd_wen_o = out_vld & sel_p.rd_wen;
   assign out_pc_o     = sel_p.pc;
   assign out_src1_o   = sel_p.src1;
   assign out_src2_o   = sel_p.src2;
   assign out_imm_o    = sel_p.imm;
   assign out_rd_o     = sel_p.rd;

   a_opinfo_onehot: assert property (@(posedge clk) disable iff (rst)
                                     (in_valid_i && in_ready_o) |-> $onehot(in_opinfo_i));

endmodule

// File: tb/tb_id_ex_issue_buf.sv
// Self-checking bench for id_ex_issue_buf: directed scenarios plus random traffic
// checked against a capacity-2 queue model.
module tb_id_ex_issue_buf;
   import id_ex_issue_buf_pkg::*;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   flush_i = 1'b0;
   logic   in_valid = 1'b0;
   logic   out_ready = 1'b0;
   issue_t in_p = '0;
   logic   in_ready;
   logic   out_valid;
   logic [OPINFO_W-1:0] out_opinfo;
   logic [ALU_W-1:0]    out_alu;
   logic [XLEN-1:0]     out_pc, out_src1, out_src2, out_imm;
   logic [RIDX_W-1:0]   out_rd;
   logic                out_rd_wen;
   issue_t out_p;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   id_ex_issue_buf dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_opinfo_i(in_p.opinfo), .in_alu_i(in_p.alu), .in_pc_i(in_p.pc),
      .in_src1_i(in_p.src1), .in_src2_i(in_p.src2), .in_imm_i(in_p.imm),
      .in_rd_i(in_p.rd), .in_rd_wen_i(in_p.rd_wen),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_opinfo_o(out_opinfo), .out_alu_o(out_alu), .out_pc_o(out_pc),
      .out_src1_o(out_src1), .out_src2_o(out_src2), .out_imm_o(out_imm),
      .out_rd_o(out_rd), .out_rd_wen_o(out_rd_wen)
   );

   assign out_p = '{opinfo: out_opinfo, alu: out_alu, pc: out_pc, src1: out_src1,
                    src2: out_src2, imm: out_imm, rd: out_rd, rd_wen: out_rd_wen};

   function automatic issue_t mk();
      issue_t p;
      p = '0;
      p.opinfo[$urandom_range(OPINFO_W-1, 0)] = 1'b1;
      p.alu[$urandom_range(ALU_W-1, 0)] = 1'b1;
      p.pc     = {$urandom, $urandom};
      p.src1   = {$urandom, $urandom};
      p.src2   = {$urandom, $urandom};
      p.imm    = {$urandom, $urandom};
      p.rd     = RIDX_W'($urandom);
      p.rd_wen = 1'($urandom);
      return p;
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_p = mk(); out_ready = 1'b0; flush_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      tests++; if (out_p !== '0) begin fails++; $display("FAIL reset_payload got=%h exp=0", out_p); end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      issue_t a;
      a = '0;
      a.opinfo[OP_ALUI] = 1'b1;
      a.alu[ALU_ADD] = 1'b1;
      a.pc = 64'h8000_0000; a.src1 = 64'd7; a.imm = 64'd5; a.rd = 5'd3; a.rd_wen = 1'b1;
      in_valid = 1'b1; in_p = a; out_ready = 1'b1;
      @(negedge clk);
`ifdef IDEX_ISSUE_BYPASS_EN
      tests++; if (out_valid !== 1'b1 || out_p !== a) begin fails++; $display("FAIL single_bypass got=%b/%h exp=1/%h", out_valid, out_p, a); end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_bypass_empty got=%b exp=0", out_valid); end
`else
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_same_cycle got=%b exp=0", out_valid); end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      tests++; if (out_p !== a) begin fails++; $display("FAIL single_payload got=%h exp=%h", out_p, a); end
      @(posedge clk); #1;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || out_opinfo !== '0 || out_alu !== '0 || out_rd_wen !== 1'b0)
         begin fails++; $display("FAIL single_bubble got v=%b op=%h alu=%h wen=%b exp=0", out_valid, out_opinfo, out_alu, out_rd_wen); end
      tests++; if (out_pc !== a.pc) begin fails++; $display("FAIL single_pc_hold got=%h exp=%h", out_pc, a.pc); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      issue_t exp_q[$];
      issue_t got_q[$];
      issue_t a, b, c;
      a = mk(); b = mk(); c = mk();
      exp_q = '{a, b, c};
      out_ready = 1'b0; in_valid = 1'b1; in_p = a;
      @(posedge clk); #1 in_p = b;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_for_b got=%b exp=1", in_ready); end
      @(posedge clk); #1 in_p = c;
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got=%b exp=0", in_ready); end
      tests++; if (out_valid !== 1'b1 || out_p !== a) begin fails++; $display("FAIL bp_head got=%b/%h exp=1/%h", out_valid, out_p, a); end
      @(posedge clk); #1 out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic acc;
         @(negedge clk);
         if (out_valid && out_ready) got_q.push_back(out_p);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) in_valid = 1'b0;
      end
      tests++; if (got_q.size() != 3) begin fails++; $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      issue_t e;
      int seen;
      out_ready = 1'b0; in_valid = 1'b1; in_p = mk();
      @(posedge clk); #1 in_p = mk();
      @(posedge clk); #1 flush_i = 1'b1; in_p = mk();
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_prefill got=%b exp=0", in_ready); end
      @(posedge clk); #1 flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_rd_wen !== 1'b0)
         begin fails++; $display("FAIL flush_empty got v=%b rdy=%b wen=%b exp 0/1/0", out_valid, in_ready, out_rd_wen); end
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (out_valid) seen++;
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL flush_dropped got=%0d exp=0", seen); end
      e = mk();
      @(posedge clk); #1 in_valid = 1'b1; in_p = e;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_p !== e) begin fails++; $display("FAIL flush_recover got=%b/%h exp=1/%h", out_valid, out_p, e); end
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   task automatic test_random();
      issue_t q[$];
      issue_t view[$];
      logic   exp_rdy, exp_vld, acc, drn;
      in_valid = 1'b0; out_ready = 1'b0; flush_i = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (!in_valid) begin
            in_valid = ($urandom_range(99, 0) < 60);
            in_p = mk();
         end
         out_ready = ($urandom_range(99, 0) < 55);
         flush_i = ($urandom_range(99, 0) < 2);
         view = q;
`ifdef IDEX_ISSUE_BYPASS_EN
         if (q.size() == 0 && in_valid && !flush_i) view.push_back(in_p);
`endif
         exp_rdy = (q.size() < 2);
         exp_vld = (view.size() > 0);
         @(negedge clk);
         tests++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
         tests++; if (out_valid !== exp_vld) begin fails++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_vld); end
         if (exp_vld) begin
            tests++; if (out_p !== view[0]) begin fails++; $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", cyc, out_p, view[0]); end
         end else begin
            tests++; if (out_opinfo !== '0 || out_alu !== '0 || out_rd_wen !== 1'b0)
               begin fails++; $display("FAIL rnd_bubble cyc=%0d got op=%h alu=%h wen=%b exp=0", cyc, out_opinfo, out_alu, out_rd_wen); end
         end
         tests++; if (!in_ready && !out_valid) begin fails++; $display("FAIL rnd_skid_implies_main cyc=%0d got rdy=0 vld=0 exp vld=1", cyc); end
         acc = in_valid && exp_rdy;
         drn = exp_vld && out_ready;
         if (flush_i) begin
            q.delete();
         end else begin
            if (acc) q.push_back(in_p);
            if (drn) void'(q.pop_front());
         end
         @(posedge clk); #1;
         if (acc || flush_i) in_valid = 1'b0;
      end
      in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
   endtask

`ifdef IDEX_ISSUE_BYPASS_EN
   task automatic test_bypass();
      issue_t a;
      a = mk();
      flush_i = 1'b1;
      @(posedge clk); #1 flush_i = 1'b0; in_valid = 1'b1; in_p = a; out_ready = 1'b1;
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_p !== a) begin fails++; $display("FAIL bypass_same_cycle got=%b/%h exp=1/%h", out_valid, out_p, a); end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bypass_not_stored got=%b exp=0", out_valid); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_flush();
      test_random();
`ifdef IDEX_ISSUE_BYPASS_EN
      test_bypass();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
